// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer (addi/add/sub/beq/bne subset).
// Walks FETCH -> DECODE -> EXEC for every instruction, owns the PC and the
// instruction register, and drives the register-file/ALU datapath controls.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             advance enable; low holds all state and blocks writes
//   instr          synchronous instruction memory read data
//   eq             datapath compare flag used to resolve branches
//   instr_addr, pc instruction fetch address / current program counter
//   regWrite       register file write enable (EXEC only)
//   ALUctrl        000 add, 001 sub
//   ALUsrc         0 = rd2, 1 = ImmOp
//   ImmOp          sign-extended immediate for the instruction in IR
//   rs1, rs2, rd   register addresses from IR
//   state          FETCH 00, DECODE 01, EXEC 10, ERR 11
//   retired        retired instruction count (wraps)
//   err            high while trapped in ERR
module multicycle_ctrl #(
   parameter int unsigned          A_WIDTH  = 5,
   parameter int unsigned          D_WIDTH  = 32,
   parameter int unsigned          PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [D_WIDTH-1:0]   instr,
   input  logic                 eq,
   output logic [PC_WIDTH-1:0]  instr_addr,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 regWrite,
   output logic [2:0]           ALUctrl,
   output logic                 ALUsrc,
   output logic [D_WIDTH-1:0]   ImmOp,
   output logic [A_WIDTH-1:0]   rs1,
   output logic [A_WIDTH-1:0]   rs2,
   output logic [A_WIDTH-1:0]   rd,
   output logic [1:0]           state,
   output logic [15:0]          retired,
   output logic                 err
);

   localparam int unsigned RET_WIDTH = 16;
   localparam logic [D_WIDTH-1:0] NOP = D_WIDTH'(32'h0000_0013);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      FETCH  = 2'b00,
      DECODE = 2'b01,
      EXEC   = 2'b10,
      ERR    = 2'b11
   } state_t;

   state_t                  state_q, state_d;
   logic [PC_WIDTH-1:0]     pc_q, pc_d;
   logic [D_WIDTH-1:0]      ir_q, ir_d;
   logic [RET_WIDTH-1:0]    retired_q, retired_d;

   logic [6:0]              opcode;
   logic [2:0]              funct3;
   logic [6:0]              funct7;
   logic                    is_addi, is_add, is_sub, is_beq, is_bne;
   logic                    is_alu, is_branch, legal, taken;
   logic [D_WIDTH-1:0]      imm_i, imm_b, imm;
   logic [PC_WIDTH-1:0]     imm_pc, pc_seq, pc_target;
   logic                    regwrite_c;
   logic [2:0]              aluctrl_c;

   // Instruction decode, purely from IR
   always_comb begin
      opcode    = ir_q[6:0];
      funct3    = ir_q[14:12];
      funct7    = ir_q[31:25];
      is_addi   = (opcode == OP_IMM) && (funct3 == 3'b000);
      is_add    = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
      is_sub    = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
      is_beq    = (opcode == OP_BRANCH) && (funct3 == 3'b000);
      is_bne    = (opcode == OP_BRANCH) && (funct3 == 3'b001);
      is_alu    = is_addi | is_add | is_sub;
      is_branch = is_beq | is_bne;
      legal     = is_alu | is_branch;
      taken     = (is_beq & eq) | (is_bne & ~eq);
      imm_i     = {{(D_WIDTH-12){ir_q[31]}}, ir_q[31:20]};
      imm_b     = {{(D_WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      imm       = is_branch ? imm_b : imm_i;
      imm_pc    = PC_WIDTH'($signed(imm));
      pc_seq    = pc_q + PC_WIDTH'(4);
      pc_target = pc_q + imm_pc;
   end

   // Next-state and control outputs
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      retired_d  = retired_q;
      regwrite_c = 1'b0;
      aluctrl_c  = 3'b000;

      // ALU op is a pure EXEC decode; en only gates state and writes
      if (state_q == EXEC && (is_sub || is_branch)) begin
         aluctrl_c = 3'b001;
      end

      if (en) begin
         case (state_q)
            FETCH: begin
               state_d = DECODE;
            end
            DECODE: begin
               ir_d    = instr;
               state_d = EXEC;
            end
            EXEC: begin
               if (!legal) begin
                  state_d = ERR;
               end else if (is_branch && taken && imm[1]) begin
                  // misaligned branch target traps without moving pc
                  state_d = ERR;
               end else begin
                  pc_d       = (is_branch && taken) ? pc_target : pc_seq;
                  retired_d  = retired_q + RET_WIDTH'(1);
                  regwrite_c = is_alu && (ir_q[11:7] != 5'd0);
                  state_d    = FETCH;
               end
            end
            ERR: begin
               state_d = ERR;
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= NOP;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         retired_q <= retired_d;
      end
   end

   assign instr_addr = pc_q;
   assign pc         = pc_q;
   assign regWrite   = regwrite_c;
   assign ALUctrl    = aluctrl_c;
   assign ALUsrc     = is_addi;
   assign ImmOp      = imm;
   assign rs1        = A_WIDTH'(ir_q[19:15]);
   assign rs2        = A_WIDTH'(ir_q[24:20]);
   assign rd         = A_WIDTH'(ir_q[11:7]);
   assign state      = state_q;
   assign retired    = retired_q;
   assign err        = (state_q == ERR);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl with a synchronous instruction memory model.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] instr;
   logic        eq;
   logic [31:0] instr_addr, pc, ImmOp;
   logic        regWrite, ALUsrc, err;
   logic [2:0]  ALUctrl;
   logic [4:0]  rs1, rs2, rd;
   logic [1:0]  state;
   logic [15:0] retired;

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;
   localparam logic [31:0] ADDI_X0_7 = 32'h0070_0013;
   localparam logic [31:0] BEQ_M8    = 32'hFE20_8CE3;  // beq x1,x2,-8
   localparam logic [31:0] BNE_M8    = 32'hFE20_9CE3;  // bne x1,x2,-8
   localparam logic [31:0] BNE_P2    = 32'h0020_9163;  // bne x1,x2,+2
   localparam logic [31:0] ADD_X3    = 32'h0020_81B3;  // add x3,x1,x2
   localparam logic [31:0] SUB_X3    = 32'h4020_81B3;  // sub x3,x1,x2

   logic [31:0] mem [0:63];

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .en(en), .instr(instr), .eq(eq),
      .instr_addr(instr_addr), .pc(pc), .regWrite(regWrite),
      .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .ImmOp(ImmOp),
      .rs1(rs1), .rs2(rs2), .rd(rd), .state(state),
      .retired(retired), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) instr <= mem[instr_addr[7:2]];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      en  = 1'b1;
   endtask

   task automatic fill_nops();
      for (int i = 0; i < 64; i++) mem[i] = NOP;
   endtask

   task automatic test_reset();
      fill_nops();
      eq = 1'b0;
      do_reset();
      vectors++; if (pc !== 32'd0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0); end
      vectors++; if (state !== 2'b00) begin miscompares++; $display("FAIL reset_state: got %b expected %b", state, 2'b00); end
      vectors++; if (retired !== 16'd0) begin miscompares++; $display("FAIL reset_retired: got %0d expected %0d", retired, 0); end
      vectors++; if (regWrite !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_we_err: got %b%b expected 00", regWrite, err); end
      vectors++; if (ALUsrc !== 1'b1 || ImmOp !== 32'd0 || rd !== 5'd0) begin miscompares++; $display("FAIL reset_ir_nop: got src=%b imm=%h rd=%0d expected src=1 imm=0 rd=0", ALUsrc, ImmOp, rd); end
   endtask

   task automatic test_addi();
      fill_nops();
      mem[0] = ADDI_X1_5;
      mem[1] = ADDI_X0_7;
      do_reset();
      step(1);
      vectors++; if (state !== 2'b01) begin miscompares++; $display("FAIL addi_decode_state: got %b expected %b", state, 2'b01); end
      vectors++; if (regWrite !== 1'b0) begin miscompares++; $display("FAIL addi_decode_we: got %b expected 0", regWrite); end
      step(1);
      vectors++; if (state !== 2'b10) begin miscompares++; $display("FAIL addi_exec_state: got %b expected %b", state, 2'b10); end
      vectors++; if (ALUsrc !== 1'b1 || ALUctrl !== 3'b000) begin miscompares++; $display("FAIL addi_exec_alu: got src=%b ctrl=%b expected src=1 ctrl=000", ALUsrc, ALUctrl); end
      vectors++; if (ImmOp !== 32'd5 || rd !== 5'd1) begin miscompares++; $display("FAIL addi_exec_imm_rd: got imm=%h rd=%0d expected imm=5 rd=1", ImmOp, rd); end
      vectors++; if (regWrite !== 1'b1) begin miscompares++; $display("FAIL addi_exec_we: got %b expected 1", regWrite); end
      step(1);
      vectors++; if (pc !== 32'd4 || retired !== 16'd1 || state !== 2'b00) begin miscompares++; $display("FAIL addi_done: got pc=%h ret=%0d st=%b expected pc=4 ret=1 st=00", pc, retired, state); end
      step(2);
      vectors++; if (regWrite !== 1'b0 || rd !== 5'd0) begin miscompares++; $display("FAIL addi_x0_we: got we=%b rd=%0d expected we=0 rd=0", regWrite, rd); end
      step(1);
      vectors++; if (pc !== 32'd8 || retired !== 16'd2) begin miscompares++; $display("FAIL addi_x0_done: got pc=%h ret=%0d expected pc=8 ret=2", pc, retired); end
   endtask

   task automatic test_branch();
      fill_nops();
      mem[4] = BEQ_M8;
      eq = 1'b1;
      do_reset();
      step(12);
      vectors++; if (pc !== 32'd16 || retired !== 16'd4) begin miscompares++; $display("FAIL br_reach16: got pc=%h ret=%0d expected pc=10 ret=4", pc, retired); end
      step(2);
      vectors++; if (ImmOp !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL br_imm: got %h expected %h", ImmOp, 32'hFFFF_FFF8); end
      vectors++; if (ALUctrl !== 3'b001 || ALUsrc !== 1'b0 || regWrite !== 1'b0) begin miscompares++; $display("FAIL br_ctrl: got ctrl=%b src=%b we=%b expected 001 0 0", ALUctrl, ALUsrc, regWrite); end
      vectors++; if (rs1 !== 5'd1 || rs2 !== 5'd2) begin miscompares++; $display("FAIL br_regs: got rs1=%0d rs2=%0d expected 1 2", rs1, rs2); end
      step(1);
      vectors++; if (pc !== 32'd8 || retired !== 16'd5) begin miscompares++; $display("FAIL beq_taken: got pc=%h ret=%0d expected pc=8 ret=5", pc, retired); end
      step(6);
      eq = 1'b0;
      step(3);
      vectors++; if (pc !== 32'd20 || retired !== 16'd8) begin miscompares++; $display("FAIL beq_not_taken: got pc=%h ret=%0d expected pc=14 ret=8", pc, retired); end
      mem[4] = BNE_M8;
      eq = 1'b1;
      do_reset();
      step(15);
      vectors++; if (pc !== 32'd20 || state !== 2'b00) begin miscompares++; $display("FAIL bne_not_taken: got pc=%h st=%b expected pc=14 st=00", pc, state); end
   endtask

   task automatic test_misaligned();
      fill_nops();
      mem[0] = BNE_P2;
      mem[1] = BNE_P2;
      eq = 1'b1;
      do_reset();
      step(3);
      vectors++; if (pc !== 32'd4 || state !== 2'b00 || retired !== 16'd1) begin miscompares++; $display("FAIL mis_not_taken: got pc=%h st=%b ret=%0d expected 4 00 1", pc, state, retired); end
      eq = 1'b0;
      step(2);
      vectors++; if (ImmOp !== 32'd2) begin miscompares++; $display("FAIL mis_imm: got %h expected 2", ImmOp); end
      step(1);
      vectors++; if (state !== 2'b11 || err !== 1'b1 || pc !== 32'd4 || retired !== 16'd1) begin miscompares++; $display("FAIL mis_trap: got st=%b err=%b pc=%h ret=%0d expected 11 1 4 1", state, err, pc, retired); end
   endtask

   task automatic test_illegal();
      fill_nops();
      mem[1] = 32'hFFFF_FFFF;
      eq = 1'b0;
      do_reset();
      step(5);
      vectors++; if (state !== 2'b10 || regWrite !== 1'b0) begin miscompares++; $display("FAIL ill_exec: got st=%b we=%b expected 10 0", state, regWrite); end
      step(1);
      vectors++; if (state !== 2'b11 || err !== 1'b1 || pc !== 32'd4) begin miscompares++; $display("FAIL ill_trap: got st=%b err=%b pc=%h expected 11 1 4", state, err, pc); end
      for (int i = 0; i < 10; i++) begin
         eq = ~eq;
         step(1);
         vectors++; if (state !== 2'b11 || pc !== 32'd4 || retired !== 16'd1 || regWrite !== 1'b0) begin miscompares++; $display("FAIL ill_hold%0d: got st=%b pc=%h ret=%0d we=%b expected 11 4 1 0", i, state, pc, retired, regWrite); end
      end
      do_reset();
      vectors++; if (state !== 2'b00 || err !== 1'b0 || pc !== 32'd0 || retired !== 16'd0) begin miscompares++; $display("FAIL ill_exit: got st=%b err=%b pc=%h ret=%0d expected 00 0 0 0", state, err, pc, retired); end
   endtask

   task automatic test_stall();
      fill_nops();
      mem[0] = ADD_X3;
      do_reset();
      step(2);
      vectors++; if (state !== 2'b10 || regWrite !== 1'b1) begin miscompares++; $display("FAIL stall_exec: got st=%b we=%b expected 10 1", state, regWrite); end
      en = 1'b0;
      #1;
      vectors++; if (regWrite !== 1'b0) begin miscompares++; $display("FAIL stall_we_forced: got %b expected 0", regWrite); end
      for (int i = 0; i < 4; i++) begin
         step(1);
         vectors++; if (state !== 2'b10 || pc !== 32'd0 || retired !== 16'd0 || regWrite !== 1'b0) begin miscompares++; $display("FAIL stall_hold%0d: got st=%b pc=%h ret=%0d we=%b expected 10 0 0 0", i, state, pc, retired, regWrite); end
      end
      en = 1'b1;
      #1;
      vectors++; if (regWrite !== 1'b1 || rd !== 5'd3 || ALUctrl !== 3'b000 || ALUsrc !== 1'b0) begin miscompares++; $display("FAIL stall_resume: got we=%b rd=%0d ctrl=%b src=%b expected 1 3 000 0", regWrite, rd, ALUctrl, ALUsrc); end
      step(1);
      vectors++; if (pc !== 32'd4 || retired !== 16'd1 || regWrite !== 1'b0) begin miscompares++; $display("FAIL stall_done: got pc=%h ret=%0d we=%b expected 4 1 0", pc, retired, regWrite); end
   endtask

   task automatic test_back_to_back();
      int pulses;
      logic [2:0] sub_ctrl;
      fill_nops();
      mem[0] = ADD_X3;
      mem[1] = SUB_X3;
      mem[2] = ADDI_X1_5;
      do_reset();
      pulses   = 0;
      sub_ctrl = 3'b000;
      for (int i = 0; i < 9; i++) begin
         if (regWrite === 1'b1) pulses++;
         if (i == 5) sub_ctrl = ALUctrl;
         step(1);
      end
      vectors++; if (pulses != 3) begin miscompares++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
      vectors++; if (sub_ctrl !== 3'b001) begin miscompares++; $display("FAIL b2b_sub_ctrl: got %b expected 001", sub_ctrl); end
      vectors++; if (pc !== 32'd12 || retired !== 16'd3) begin miscompares++; $display("FAIL b2b_throughput: got pc=%h ret=%0d expected c 3", pc, retired); end
   endtask

   task automatic test_async_reset();
      fill_nops();
      mem[0] = ADDI_X1_5;
      mem[1] = ADDI_X1_5;
      do_reset();
      step(4);
      vectors++; if (state !== 2'b01 || pc !== 32'd4 || rd !== 5'd1) begin miscompares++; $display("FAIL ar_setup: got st=%b pc=%h rd=%0d expected 01 4 1", state, pc, rd); end
      #2;
      rst = 1'b1;
      #1;
      vectors++; if (state !== 2'b00 || pc !== 32'd0 || retired !== 16'd0 || rd !== 5'd0 || regWrite !== 1'b0) begin miscompares++; $display("FAIL ar_immediate: got st=%b pc=%h ret=%0d rd=%0d we=%b expected 00 0 0 0 0", state, pc, retired, rd, regWrite); end
      step(1);
      vectors++; if (state !== 2'b00 || regWrite !== 1'b0) begin miscompares++; $display("FAIL ar_held: got st=%b we=%b expected 00 0", state, regWrite); end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      eq  = 1'b0;
      test_reset();
      test_addi();
      test_branch();
      test_misaligned();
      test_illegal();
      test_stall();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
